partial_sum_accumulator: RTL and testbench

PARTIAL_SUM_ACCUMULATOR -- requirements
Module: partial_sum_accumulator

---
 rtl/partial_sum_accumulator_pkg.sv | 13 +
 rtl/partial_sum_accumulator_saturator.sv | 24 ++
 rtl/partial_sum_accumulator.sv | 114 +++++++++++
 tb/tb_partial_sum_accumulator.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/partial_sum_accumulator_pkg.sv
// Shared defaults and FSM state type for the partial-sum accumulator.
package accumulator_pkg;

    localparam int unsigned DEF_IN_WIDTH  = 16;
    localparam int unsigned DEF_MAX_TERMS = 16;
    localparam int unsigned DEF_OUT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/partial_sum_accumulator_saturator.sv
// Combinational signed clamp of an IN_W value into the OUT_W signed range.
module saturator #(
    parameter int unsigned IN_W  = 21,
    parameter int unsigned OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] clamped,
    output logic                    sat_flag
);

    logic [IN_W-OUT_W:0] upper;

    // In range exactly when every bit above the result's sign bit copies it.
    always_comb begin
        upper    = value[IN_W-1:OUT_W-1];
        sat_flag = !((&upper) || !(|upper));
        clamped  = value[OUT_W-1:0];
        if (sat_flag) begin
            clamped = value[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/partial_sum_accumulator.sv
// Accumulates signed product terms per group and emits one saturated sum per group.
module partial_sum_accumulator
    import accumulator_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned MAX_TERMS = DEF_MAX_TERMS,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned ACC_WIDTH = IN_WIDTH + $clog2(MAX_TERMS) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic signed [IN_WIDTH-1:0]           in_data,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic signed [OUT_WIDTH-1:0]          out_data,
    output logic                                 out_sat,
    output logic [$clog2(MAX_TERMS+1)-1:0]       out_count,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 err_overrun
);

    localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);

    acc_state_e                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum_c;
    logic [CNT_W-1:0]            count_q, count_d, count_inc_c;
    logic signed [OUT_WIDTH-1:0] sat_data_c, out_data_d;
    logic                        sat_flag_c, out_sat_d, out_valid_d, err_d;
    logic [CNT_W-1:0]            out_count_d;
    logic                        accept_c;

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;
    assign sum_c    = acc_q + {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    // Term count sticks at MAX_TERMS once a group overruns.
    assign count_inc_c = (count_q == CNT_W'(MAX_TERMS)) ? count_q : count_q + CNT_W'(1);

    saturator #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (OUT_WIDTH)
    ) u_sat (
        .value    (sum_c),
        .clamped  (sat_data_c),
        .sat_flag (sat_flag_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            state_d = in_last ? IDLE : ACCUM;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data;
        out_sat_d   = out_sat;
        out_count_d = out_count;
        out_valid_d = out_valid;
        err_d       = err_overrun;
        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept_c) begin
            if (in_last) begin
                acc_d       = '0;
                count_d     = '0;
                out_data_d  = sat_data_c;
                out_sat_d   = sat_flag_c;
                out_count_d = count_inc_c;
                out_valid_d = 1'b1;
            end else begin
                acc_d   = sum_c;
                count_d = count_inc_c;
                if (count_inc_c == CNT_W'(MAX_TERMS)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            out_data    <= '0;
            out_sat     <= 1'b0;
            out_count   <= '0;
            out_valid   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data    <= out_data_d;
            out_sat     <= out_sat_d;
            out_count   <= out_count_d;
            out_valid   <= out_valid_d;
            err_overrun <= err_d;
        end
    end

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic against a group-level model.
module tb_partial_sum_accumulator;

    localparam int unsigned IN_WIDTH  = 16;
    localparam int unsigned MAX_TERMS = 16;
    localparam int unsigned OUT_WIDTH = 8;
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_sat;
    logic [CNT_W-1:0]            out_count;
    logic                        out_valid;
    logic                        out_ready;
    logic                        err_overrun;

    partial_sum_accumulator #(
        .IN_WIDTH  (IN_WIDTH),
        .MAX_TERMS (MAX_TERMS),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_count   (out_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: terms of the open group and the last produced result.
    int grp[$];
    int m_data  = 0;
    int m_sat   = 0;
    int m_count = 0;
    int m_valid = 0;
    int m_err   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input int d, input logic l, input logic ordy, input logic r);
        int sum;
        logic acc;
        if (r) begin
            grp.delete();
            m_data = 0; m_sat = 0; m_count = 0; m_valid = 0; m_err = 0;
            return;
        end
        acc = v && (m_valid == 0 || ordy);
        if (m_valid != 0 && ordy) m_valid = 0;
        if (acc) begin
            grp.push_back(d);
            if (l) begin
                sum = 0;
                foreach (grp[i]) sum += grp[i];
                m_sat = 0;
                if (sum > 127)  begin sum = 127;  m_sat = 1; end
                if (sum < -128) begin sum = -128; m_sat = 1; end
                m_data  = sum;
                m_count = (grp.size() > MAX_TERMS) ? MAX_TERMS : grp.size();
                m_valid = 1;
                grp.delete();
            end else if (grp.size() >= MAX_TERMS) begin
                m_err = 1;
            end
        end
    endtask

    // One clock: drive at negedge, check in_ready, clock, then check registered outputs.
    task automatic cycle(input logic v, input int d, input logic l, input logic ordy, input logic r);
        in_valid  = v;
        in_data   = IN_WIDTH'(d);
        in_last   = l;
        out_ready = ordy;
        rst       = r;
        #1;
        check("in_ready", int'(in_ready), (m_valid == 0 || ordy) ? 1 : 0);
        @(posedge clk);
        model_step(v, d, l, ordy, r);
        #1;
        check("out_valid", int'(out_valid), m_valid);
        check("out_data", int'(out_data), m_data);
        check("out_sat", int'(out_sat), m_sat);
        check("out_count", int'(out_count), m_count);
        check("err_overrun", int'(err_overrun), m_err);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle(0, 0, 0, 1, 1);

        // basic group 3 + -5 + 10
        cycle(1, 3, 0, 1, 0);
        cycle(1, -5, 0, 1, 0);
        cycle(1, 10, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // positive and negative saturation
        cycle(1, 100, 0, 1, 0);
        cycle(1, 100, 1, 1, 0);
        cycle(1, -100, 0, 1, 0);
        cycle(1, -100, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // single-term group then downstream stall with a pending beat
        cycle(1, -7, 1, 0, 0);
        repeat (5) cycle(1, -1, 1, 0, 0);
        cycle(1, -1, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // reset in the middle of a group
        cycle(1, 5, 0, 1, 0);
        cycle(1, 6, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(1, 2, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // overrun: 17 ones, last only on the 17th
        for (int i = 1; i <= 17; i++) cycle(1, 1, (i == 17), 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);

        // back-to-back single-term groups
        cycle(1, 1, 1, 1, 0);
        cycle(1, 2, 1, 1, 0);
        cycle(1, 3, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            int x;
            x = int'($urandom_range(4000)) - 2000;
            if ($urandom_range(3) == 0) x = int'($urandom_range(200)) - 100;
            cycle($urandom_range(3) != 0, x, $urandom_range(4) == 0,
                  $urandom_range(3) != 0, $urandom_range(60) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
